// File: rtl/hyper_target.sv
// hyper_target: HyperBus memory-side target running single-data-rate, one bus
// byte per clk_i. Decodes the 48-bit command-address, waits the initial
// latency, then serves linear or wrapped bursts from an internal 16-bit SRAM
// or the ID/CR0 register space.
// Optional feature macro: HYPER_TARGET_DBL_LAT_EN -- flags doubled latency on
// rwds during command-address and doubles the memory initial latency.
module hyper_target #(
  parameter int          MemAddrWidth  = 10,
  parameter int          LatencyCycles = 6,
  parameter logic [15:0] IdValue       = 16'h0C81,
  parameter logic [15:0] Cr0Reset      = 16'h8F1F
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hyper_cs_ni,
  input  logic [7:0]  hyper_dq_i,
  output logic [7:0]  hyper_dq_o,
  output logic        hyper_dq_oe_o,
  input  logic        hyper_rwds_i,
  output logic        hyper_rwds_o,
  output logic        hyper_rwds_oe_o,
  output logic [15:0] cr0_o
);

`ifdef HYPER_TARGET_DBL_LAT_EN
  localparam int   LatTotal     = 2 * LatencyCycles;
  localparam logic LatIndicator = 1'b1;
`else
  localparam int   LatTotal     = LatencyCycles;
  localparam logic LatIndicator = 1'b0;
`endif
  localparam int LatW  = $clog2(LatTotal + 1);
  localparam int Words = 2 ** MemAddrWidth;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CA      = 3'd1,
    LAT     = 3'd2,
    WR      = 3'd3,
    RD      = 3'd4,
    WAIT_CS = 3'd5
  } state_e;

  state_e                  state;
  logic [2:0]              ca_cnt;
  logic [LatW-1:0]         lat_cnt;
  logic                    is_read_q;
  logic                    is_reg_q;
  logic                    is_lin_q;
  logic                    addr0_q;
  logic                    wr_phase;
  logic                    rd_phase;
  logic [15:0]             cr0_q;

  // Data-path registers (no reset: their contents only matter once the
  // control path has qualified them).
  logic [39:0]             ca_sr;
  logic [MemAddrWidth-1:0] addr_q;
  logic [7:0]              wr_hi_q;
  logic                    wr_hi_en_q;
  logic [15:0]             rd_word_p1;
  logic [7:0]              rd_lo_p2;
  logic [15:0]             mem [Words];

  logic [47:0]             ca_full;
  logic [31:0]             ca_word;
  logic [MemAddrWidth-1:0] ca_addr;
  logic                    mem_re;
  logic                    mem_we;
  logic [1:0]              wr_be;
  logic [15:0]             reg_word;
  logic [15:0]             src_word;
  logic                    unused_ca;

  // Next burst address: linear wraps over the whole array, wrapped bursts stay
  // inside the aligned window selected by CR0[1:0].
  function automatic logic [MemAddrWidth-1:0] next_addr(
    input logic [MemAddrWidth-1:0] a,
    input logic                    lin,
    input logic [1:0]              wsel
  );
    logic [MemAddrWidth-1:0] inc;
    logic [MemAddrWidth-1:0] mask;
    inc = a + 1'b1;
    case (wsel)
      2'b00:   mask = MemAddrWidth'(6'd63);
      2'b01:   mask = MemAddrWidth'(6'd31);
      2'b10:   mask = MemAddrWidth'(6'd7);
      default: mask = MemAddrWidth'(6'd15);
    endcase
    if (lin) next_addr = inc;
    else     next_addr = (a & ~mask) | (inc & mask);
  endfunction

  // The sixth CA byte is consumed straight from the bus, so the full CA word
  // is available for decode in that same cycle.
  assign ca_full   = {ca_sr, hyper_dq_i};
  assign ca_word   = {ca_full[44:16], ca_full[2:0]};
  assign ca_addr   = ca_word[MemAddrWidth-1:0];
  assign unused_ca = ^{ca_full[15:3], ca_word[31:MemAddrWidth]};

  // Memory reads are issued once at the end of latency and then on every
  // upper-byte cycle, which keeps the next word ready for gapless bursts.
  assign mem_re = !is_reg_q &&
                  (((state == LAT) && (lat_cnt == '0) && is_read_q) ||
                   ((state == RD) && !rd_phase));
  // A word commits only on its lower-byte cycle while CS is still low, so an
  // aborted odd byte never reaches the array.
  assign mem_we = !rst_i && !hyper_cs_ni && !is_reg_q && (state == WR) && wr_phase;
  assign wr_be  = {wr_hi_en_q, ~hyper_rwds_i};

  assign reg_word = addr0_q ? IdValue : cr0_q;
  assign src_word = is_reg_q ? reg_word : rd_word_p1;

  assign hyper_dq_o = hyper_dq_oe_o ? (rd_phase ? rd_lo_p2 : src_word[15:8]) : 8'h00;
  assign cr0_o      = cr0_q;

  // Synchronous SRAM: per-byte write enables, one-cycle registered read.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      if (wr_be[1]) mem[addr_q][15:8] <= wr_hi_q;
      if (wr_be[0]) mem[addr_q][7:0]  <= hyper_dq_i;
    end
    if (mem_re) rd_word_p1 <= mem[addr_q];
  end

  // CA shift register, burst address, held write upper byte and read lower byte.
  always_ff @(posedge clk_i) begin
    if ((state == IDLE) || (state == CA)) ca_sr <= {ca_sr[31:0], hyper_dq_i};
    if ((state == CA) && (ca_cnt == 3'd5)) addr_q <= ca_addr;
    else if (mem_re || mem_we)            addr_q <= next_addr(addr_q, is_lin_q, cr0_q[1:0]);
    if ((state == WR) && !wr_phase) begin
      wr_hi_q    <= hyper_dq_i;
      wr_hi_en_q <= ~hyper_rwds_i;
    end
    // stage boundary: lower read byte held while the next word is fetched
    if ((state == RD) && !rd_phase) rd_lo_p2 <= src_word[7:0];
  end

  // Transaction FSM with registered bus enables and rwds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      ca_cnt          <= 3'd0;
      lat_cnt         <= '0;
      is_read_q       <= 1'b0;
      is_reg_q        <= 1'b0;
      is_lin_q        <= 1'b0;
      addr0_q         <= 1'b0;
      wr_phase        <= 1'b0;
      rd_phase        <= 1'b0;
      cr0_q           <= Cr0Reset;
      hyper_dq_oe_o   <= 1'b0;
      hyper_rwds_o    <= 1'b0;
      hyper_rwds_oe_o <= 1'b0;
    end else if (hyper_cs_ni) begin
      state           <= IDLE;
      wr_phase        <= 1'b0;
      rd_phase        <= 1'b0;
      hyper_dq_oe_o   <= 1'b0;
      hyper_rwds_o    <= 1'b0;
      hyper_rwds_oe_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state           <= CA;
          ca_cnt          <= 3'd1;
          hyper_rwds_oe_o <= 1'b1;
          hyper_rwds_o    <= LatIndicator;
        end
        CA: begin
          ca_cnt <= ca_cnt + 3'd1;
          if (ca_cnt == 3'd5) begin
            is_read_q       <= ca_full[47];
            is_reg_q        <= ca_full[46];
            is_lin_q        <= ca_full[45];
            addr0_q         <= (ca_addr == '0);
            wr_phase        <= 1'b0;
            hyper_rwds_oe_o <= 1'b0;
            hyper_rwds_o    <= 1'b0;
            if (!ca_full[47] && ca_full[46]) begin
              state <= WR;
            end else begin
              state   <= LAT;
              lat_cnt <= LatW'(LatTotal - 1);
            end
          end
        end
        LAT: begin
          if (lat_cnt == '0) begin
            if (is_read_q) begin
              state           <= RD;
              rd_phase        <= 1'b0;
              hyper_dq_oe_o   <= 1'b1;
              hyper_rwds_oe_o <= 1'b1;
              hyper_rwds_o    <= 1'b1;
            end else begin
              state    <= WR;
              wr_phase <= 1'b0;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        WR: begin
          wr_phase <= ~wr_phase;
          if (wr_phase && is_reg_q) begin
            cr0_q <= {wr_hi_q, hyper_dq_i};
            state <= WAIT_CS;
          end
        end
        RD: begin
          rd_phase     <= ~rd_phase;
          hyper_rwds_o <= rd_phase;
        end
        WAIT_CS: begin
          state <= WAIT_CS;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_target.sv
// tb_hyper_target: randomized scoreboard bench for hyper_target. Stimulus
// tasks push expected read bytes (value, rwds, cycle) into a queue; a monitor
// pops and compares whenever the target drives dq.
module tb_hyper_target;
  localparam int          AW   = 10;
  localparam int          NW   = 1 << AW;
  localparam int          LAT  = 6;
  localparam logic [15:0] ID   = 16'h0C81;
  localparam logic [15:0] CR0R = 16'h8F1F;
`ifdef HYPER_TARGET_DBL_LAT_EN
  localparam int   LEFF = 2 * LAT;
  localparam logic IND  = 1'b1;
`else
  localparam int   LEFF = LAT;
  localparam logic IND  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1;
  logic [7:0]  dq_i = 8'h00;
  logic        rwds_i = 1'b0;
  logic [7:0]  dq_o;
  logic        dq_oe;
  logic        rwds_o;
  logic        rwds_oe;
  logic [15:0] cr0;

  hyper_target #(.MemAddrWidth(AW), .LatencyCycles(LAT), .IdValue(ID), .Cr0Reset(CR0R)) dut (
    .clk_i(clk), .rst_i(rst), .hyper_cs_ni(cs_n), .hyper_dq_i(dq_i), .hyper_dq_o(dq_o),
    .hyper_dq_oe_o(dq_oe), .hyper_rwds_i(rwds_i), .hyper_rwds_o(rwds_o),
    .hyper_rwds_oe_o(rwds_oe), .cr0_o(cr0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] dq;
    logic       rwds;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  logic [15:0] ref_mem [NW];
  logic [15:0] ref_cr0 = CR0R;
  logic [7:0]  wbytes [2048];
  logic        wmask  [2048];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference address sequencing from the window rules, plain arithmetic.
  function automatic int model_next(input int a, input bit lin);
    int w;
    int base;
    if (lin) return (a + 1) % NW;
    case (ref_cr0[1:0])
      2'b00:   w = 64;
      2'b01:   w = 32;
      2'b10:   w = 8;
      default: w = 16;
    endcase
    base = (a / w) * w;
    return base + ((a - base + 1) % w);
  endfunction

  function automatic logic [47:0] make_ca(input bit rd, input bit regsp, input bit lin,
                                          input logic [31:0] a);
    return {rd, regsp, lin, a[31:3], 13'd0, a[2:0]};
  endfunction

  // Monitor: every driven byte must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (dq_oe === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_dq_oe", {31'd0, dq_oe}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rd_data", {24'd0, dq_o}, {24'd0, e.dq});
        check("rd_rwds", {31'd0, rwds_o}, {31'd0, e.rwds});
        check("rd_cycle", cyc, e.cyc);
        check("rd_rwds_oe", {31'd0, rwds_oe}, 32'd1);
      end
    end
  end

  task automatic send_ca(input logic [47:0] ca, output int t0);
    t0 = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        cs_n = 1'b0;
        t0   = cyc;
      end else begin
        check("ca_rwds_oe", {31'd0, rwds_oe}, 32'd1);
        check("ca_rwds_o", {31'd0, rwds_o}, {31'd0, IND});
      end
      dq_i = ca[47-8*i -: 8];
    end
  endtask

  task automatic end_cs();
    @(posedge clk); #1;
    cs_n = 1'b1; dq_i = 8'h00; rwds_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input bit regsp, input bit lin, input logic [31:0] addr, input int nb);
    int t0;
    int a;
    send_ca(make_ca(1'b0, regsp, lin, addr), t0);
    if (!regsp) repeat (LEFF) begin @(posedge clk); #1; dq_i = 8'h00; end
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      dq_i = wbytes[i]; rwds_i = wmask[i];
    end
    end_cs();
    if (regsp) begin
      if (nb >= 2) ref_cr0 = {wbytes[0], wbytes[1]};
      check("cr0_after_reg_wr", {16'd0, cr0}, {16'd0, ref_cr0});
    end else begin
      a = int'(addr[AW-1:0]);
      for (int w = 0; w < nb / 2; w++) begin
        if (!wmask[2*w])   ref_mem[a][15:8] = wbytes[2*w];
        if (!wmask[2*w+1]) ref_mem[a][7:0]  = wbytes[2*w+1];
        a = model_next(a, lin);
      end
    end
  endtask

  // nb bytes are read with CS low; the target also drives the byte of the
  // cycle in which CS rises, then must release the bus.
  task automatic do_read(input bit regsp, input bit lin, input logic [31:0] addr, input int nb);
    int t0;
    int a;
    logic [15:0] w;
    exp_t e;
    send_ca(make_ca(1'b1, regsp, lin, addr), t0);
    a = int'(addr[AW-1:0]);
    for (int i = 0; i <= nb; i++) begin
      w = regsp ? ((a == 0) ? ID : ref_cr0) : ref_mem[a];
      e.dq   = (i % 2 == 0) ? w[15:8] : w[7:0];
      e.rwds = (i % 2 == 0);
      e.cyc  = t0 + 6 + LEFF + i;
      sb.push_back(e);
      if ((i % 2 == 1) && !regsp) a = model_next(a, lin);
    end
    repeat (LEFF) begin @(posedge clk); #1; dq_i = 8'h00; end
    repeat (nb) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    cs_n = 1'b1;
    @(posedge clk); #1;
    check("oe_after_cs", {31'd0, dq_oe}, 32'd0);
    check("rwds_oe_after_cs", {31'd0, rwds_oe}, 32'd0);
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, tests %0d", n_tests);
    $fatal(1);
  end

  initial begin
    int t0;
    int nb;
    logic [31:0] addr;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
    check("rst_rwds_oe", {31'd0, rwds_oe}, 32'd0);
    check("rst_rwds_o", {31'd0, rwds_o}, 32'd0);
    check("rst_dq_o", {24'd0, dq_o}, 32'd0);
    check("rst_cr0", {16'd0, cr0}, {16'd0, CR0R});
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill the whole array so every later read has a defined reference.
    for (int i = 0; i < 2 * NW; i++) begin
      wbytes[i] = 8'($urandom);
      wmask[i]  = 1'b0;
    end
    do_write(1'b0, 1'b1, 32'd0, 2 * NW);

    // Linear write then read.
    wbytes[0] = 8'hDE; wbytes[1] = 8'hAD; wbytes[2] = 8'hBE; wbytes[3] = 8'hEF;
    for (int i = 0; i < 4; i++) wmask[i] = 1'b0;
    do_write(1'b0, 1'b1, 32'd2, 4);
    do_read(1'b0, 1'b1, 32'd2, 4);

    // Masked lower byte: 0x1234 over 0xDEAD gives 0x12AD.
    wbytes[0] = 8'h12; wbytes[1] = 8'h34; wmask[1] = 1'b1;
    do_write(1'b0, 1'b1, 32'd2, 2);
    wmask[1] = 1'b0;
    check("masked_model", {16'd0, ref_mem[2]}, 32'h12AD);
    do_read(1'b0, 1'b1, 32'd2, 2);

    // Register write with zero latency, then register reads.
    wbytes[0] = 8'h8F; wbytes[1] = 8'h1E;
    do_write(1'b1, 1'b0, 32'd1, 2);
    check("cr0_value", {16'd0, cr0}, 32'h8F1E);
    do_read(1'b1, 1'b0, 32'd0, 4);
    do_read(1'b1, 1'b0, 32'd1, 3);

    // Wrapped 8-word window from word 6: 6,7,0..5,6,7.
    do_read(1'b0, 1'b0, 32'd6, 20);

    // Read aborted after three data bytes.
    do_read(1'b0, 1'b1, 32'd40, 3);

    // Odd-byte write abort: second word must stay untouched.
    wbytes[0] = 8'hA5; wbytes[1] = 8'h5A; wbytes[2] = 8'hC3;
    do_write(1'b0, 1'b1, 32'd100, 3);
    do_read(1'b0, 1'b1, 32'd100, 4);

    // Reset during latency.
    send_ca(make_ca(1'b1, 1'b0, 1'b1, 32'd5), t0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("lat_rst_dq_oe", {31'd0, dq_oe}, 32'd0);
    check("lat_rst_rwds_oe", {31'd0, rwds_oe}, 32'd0);
    check("lat_rst_rwds_o", {31'd0, rwds_o}, 32'd0);
    check("lat_rst_dq_o", {24'd0, dq_o}, 32'd0);
    check("lat_rst_cr0", {16'd0, cr0}, {16'd0, CR0R});
    rst = 1'b0; cs_n = 1'b1; ref_cr0 = CR0R;
    @(posedge clk); #1;
    do_read(1'b0, 1'b1, 32'd5, 4);

    // Randomized mix of memory and register traffic.
    for (int t = 0; t < 40; t++) begin
      addr = 32'($urandom_range(0, NW - 1)) | (32'($urandom_range(0, 7)) << AW);
      case ($urandom_range(0, 7))
        0: begin
          nb = $urandom_range(2, 4);
          for (int i = 0; i < nb; i++) begin wbytes[i] = 8'($urandom); wmask[i] = 1'b0; end
          do_write(1'b1, 1'b0, addr, nb);
        end
        1: do_read(1'b1, 1'b0, 32'($urandom_range(0, 2)), $urandom_range(1, 6));
        2, 3, 4: begin
          nb = $urandom_range(1, 16);
          for (int i = 0; i < nb; i++) begin
            wbytes[i] = 8'($urandom);
            wmask[i]  = ($urandom_range(0, 3) == 0);
          end
          do_write(1'b0, 1'($urandom_range(0, 1)), addr, nb);
          for (int i = 0; i < nb; i++) wmask[i] = 1'b0;
        end
        default: do_read(1'b0, 1'($urandom_range(0, 1)), addr, $urandom_range(1, 16));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
